// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcode encodings, FSM state
// type and opcode classification.
package alu_pkg;

  localparam logic [3:0] OP_ADD_LS = 4'b0000; // load/store address add
  localparam logic [3:0] OP_SUB_BR = 4'b0001; // branch compare subtract
  localparam logic [3:0] OP_ADD    = 4'b0010;
  localparam logic [3:0] OP_SUB    = 4'b0011;
  localparam logic [3:0] OP_SLL    = 4'b0100;
  localparam logic [3:0] OP_OR     = 4'b0101;
  localparam logic [3:0] OP_AND    = 4'b0110;
  localparam logic [3:0] OP_ORI    = 4'b0111;
  localparam logic [3:0] OP_XOR    = 4'b1000;
  localparam logic [3:0] OP_SRL    = 4'b1001;
  localparam logic [3:0] OP_SRA    = 4'b1010;
  localparam logic [3:0] OP_SLT    = 4'b1011;
  localparam logic [3:0] OP_SLTU   = 4'b1100;
  localparam logic [3:0] OP_MUL    = 4'b1101;
  localparam logic [3:0] OP_DIVU   = 4'b1110;
  localparam logic [3:0] OP_REMU   = 4'b1111;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  // MUL, DIVU and REMU use the multi-cycle path (unless divide by zero).
  function automatic logic is_iterative(input logic [3:0] op);
    return (op >= OP_MUL);
  endfunction

endpackage

// File: rtl/seq_alu_muldiv.sv
// Iterative WIDTH-step shift-add multiplier / restoring unsigned divider.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   start           latch op/a/b and begin iterating (ignored on div by zero)
//   op, a, b        operation and operands
//   busy            iteration in progress
//   done            this cycle performs the final step
//   div_zero        combinational: op is DIVU/REMU with b == 0
//   product_lo      low WIDTH bits of a*b   (valid when done)
//   quotient        a / b                   (valid when done)
//   remainder       a % b                   (valid when done)
module seq_alu_muldiv
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] product_lo,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int CNT_W = $clog2(WIDTH);

  // acc: partial product / partial remainder
  // x:   shifted multiplicand / dividend shifting into quotient
  // y:   multiplier shifting right / divisor
  logic [WIDTH-1:0] acc, x, y;
  logic [WIDTH-1:0] acc_nxt, x_nxt, y_nxt;
  logic [WIDTH:0]   sh, diff;
  logic [CNT_W-1:0] cnt;
  logic             is_mul;

  assign div_zero = ((op == OP_DIVU) || (op == OP_REMU)) && (b == '0);
  assign done     = busy && (cnt == CNT_W'(WIDTH - 1));

  always_comb begin
    acc_nxt = acc;
    x_nxt   = x;
    y_nxt   = y;
    sh      = {acc, x[WIDTH-1]};
    diff    = sh - {1'b0, y};
    if (is_mul) begin
      acc_nxt = y[0] ? (acc + x) : acc;
      x_nxt   = x << 1;
      y_nxt   = y >> 1;
    end else if (!diff[WIDTH]) begin
      acc_nxt = diff[WIDTH-1:0];
      x_nxt   = {x[WIDTH-2:0], 1'b1};
    end else begin
      acc_nxt = sh[WIDTH-1:0];
      x_nxt   = {x[WIDTH-2:0], 1'b0};
    end
  end

  // Results are the post-step values so the parent can register them on
  // the same edge as the final step.
  assign product_lo = acc_nxt;
  assign quotient   = x_nxt;
  assign remainder  = acc_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy   <= 1'b0;
      cnt    <= '0;
      is_mul <= 1'b0;
      acc    <= '0;
      x      <= '0;
      y      <= '0;
    end else if (start && !div_zero) begin
      busy   <= 1'b1;
      cnt    <= '0;
      is_mul <= (op == OP_MUL);
      acc    <= '0;
      x      <= a;
      y      <= b;
    end else if (busy) begin
      acc <= acc_nxt;
      x   <= x_nxt;
      y   <= y_nxt;
      cnt <= cnt + 1'b1;
      if (done) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/seq_alu.sv
// Registered ALU with valid/ready handshakes and a registered zero flag.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   input handshake (op, a, b)
//   op                    4-bit operation code
//   a, b                  operands; shifts use b[SHAMT_W-1:0]
//   out_valid / out_ready output handshake
//   result, zero          registered result and (result == 0)
module seq_alu
  import alu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero
);

  state_t           state, nstate;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] simple_res, md_res, res_nxt;
  logic [SHAMT_W-1:0] shamt;
  logic             accept, iter, load, md_start;
  logic             md_busy, md_done, md_div_zero;
  logic [WIDTH-1:0] md_prod, md_quo, md_rem;

  seq_alu_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (md_start),
    .op         (op),
    .a          (a),
    .b          (b),
    .busy       (md_busy),
    .done       (md_done),
    .div_zero   (md_div_zero),
    .product_lo (md_prod),
    .quotient   (md_quo),
    .remainder  (md_rem)
  );

  assign in_ready  = ((state == IDLE) || ((state == DONE) && out_ready)) && !md_busy;
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;
  assign iter      = is_iterative(op) && !md_div_zero;
  assign shamt     = b[SHAMT_W-1:0];

  always_comb begin
    simple_res = '0;
    case (op)
      OP_ADD_LS, OP_ADD: simple_res = a + b;
      OP_SUB_BR, OP_SUB: simple_res = a - b;
      OP_SLL:            simple_res = a << shamt;
      OP_OR, OP_ORI:     simple_res = a | b;
      OP_AND:            simple_res = a & b;
      OP_XOR:            simple_res = a ^ b;
      OP_SRL:            simple_res = a >> shamt;
      OP_SRA:            simple_res = $signed(a) >>> shamt;
      OP_SLT:            simple_res = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
      OP_SLTU:           simple_res = {{(WIDTH-1){1'b0}}, a < b};
      OP_DIVU:           simple_res = '1; // only reached on divide by zero
      OP_REMU:           simple_res = a;  // only reached on divide by zero
      default:           simple_res = '0;
    endcase
  end

  always_comb begin
    case (op_q)
      OP_MUL:  md_res = md_prod;
      OP_DIVU: md_res = md_quo;
      default: md_res = md_rem;
    endcase
  end

  // An accept in DONE is treated identically to one from IDLE.
  always_comb begin
    nstate   = state;
    load     = 1'b0;
    res_nxt  = result;
    md_start = 1'b0;
    unique case (state)
      IDLE, DONE: begin
        if (accept) begin
          if (iter) begin
            md_start = 1'b1;
            nstate   = BUSY;
          end else begin
            load    = 1'b1;
            res_nxt = simple_res;
            nstate  = DONE;
          end
        end else if ((state == DONE) && out_ready) begin
          nstate = IDLE;
        end
      end
      BUSY: begin
        if (md_done) begin
          load    = 1'b1;
          res_nxt = md_res;
          nstate  = DONE;
        end
      end
      default: nstate = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      result <= '0;
      zero   <= 1'b0;
      op_q   <= '0;
    end else begin
      state <= nstate;
      if (md_start) op_q <= op;
      if (load) begin
        result <= res_nxt;
        zero   <= (res_nxt == '0);
      end
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
module tb_seq_alu;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  op = '0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] result;
  logic        zero;

  int unsigned errors = 0;
  int unsigned checks = 0;

  always #5 clk = ~clk;

  seq_alu #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Issue one op at a negedge, wait for out_valid, check latency/result/zero.
  task automatic run_op(input string tag, input logic [3:0] o, input logic [31:0] ia,
                        input logic [31:0] ib, input logic [31:0] exp_res,
                        input logic exp_zero, input int exp_lat);
    int lat;
    logic busy_ok;
    busy_ok = 1'b1;
    check({tag, "_in_ready"}, {31'b0, in_ready}, 32'd1);
    op = o; a = ia; b = ib; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin
      if (in_ready) busy_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "_result"}, result, exp_res);
    check({tag, "_zero"}, {31'b0, zero}, {31'b0, exp_zero});
    if (exp_lat > 1) check({tag, "_busy_in_ready"}, {31'b0, busy_ok}, 32'd1);
    @(negedge clk);
  endtask

  initial begin
    logic stable;
    repeat (2) @(negedge clk);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_zero", {31'b0, zero}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);

    run_op("add",  OP_ADD,  32'd5, 32'd7, 32'd12, 1'b0, 1);
    run_op("sub",  OP_SUB,  32'd9, 32'd9, 32'd0, 1'b1, 1);
    run_op("sll",  OP_SLL,  32'd1, 32'h23, 32'h8, 1'b0, 1);
    run_op("sra",  OP_SRA,  32'h8000_0000, 32'd4, 32'hF800_0000, 1'b0, 1);
    run_op("slt",  OP_SLT,  32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 1);
    run_op("sltu", OP_SLTU, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1, 1);
    run_op("xor",  OP_XOR,  32'hF0F0_1234, 32'h0FF0_1234, 32'hFF00_0000, 1'b0, 1);
    run_op("srl",  OP_SRL,  32'h8000_0000, 32'd36, 32'h0800_0000, 1'b0, 1);
    run_op("mul",  OP_MUL,  32'd6, 32'd7, 32'd42, 1'b0, 33);
    run_op("mulw", OP_MUL,  32'h0001_0001, 32'hFFFF_0003, 32'h0002_0003, 1'b0, 33);
    run_op("divu", OP_DIVU, 32'd100, 32'd7, 32'd14, 1'b0, 33);
    run_op("remu", OP_REMU, 32'd100, 32'd7, 32'd2, 1'b0, 33);
    run_op("divbig", OP_DIVU, 32'hFFFF_FFFF, 32'h8000_0001, 32'd1, 1'b0, 33);
    run_op("div0", OP_DIVU, 32'd123, 32'd0, 32'hFFFF_FFFF, 1'b0, 1);
    run_op("rem0", OP_REMU, 32'd123, 32'd0, 32'd123, 1'b0, 1);

    // Backpressure: hold the ADD result for 5 cycles.
    out_ready = 1'b0;
    op = OP_ADD; a = 32'd3; b = 32'd4; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    stable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (!out_valid || result !== 32'd7 || zero !== 1'b0 || in_ready) stable = 1'b0;
      @(negedge clk);
    end
    check("bp_stable", {31'b0, stable}, 32'd1);
    check("bp_result", result, 32'd7);
    // Simultaneous output transfer and new SUB accept.
    out_ready = 1'b1;
    op = OP_SUB; a = 32'd10; b = 32'd4; in_valid = 1'b1;
    #1;
    check("b2b_in_ready", {31'b0, in_ready}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    check("b2b_out_valid", {31'b0, out_valid}, 32'd1);
    check("b2b_result", result, 32'd6);
    @(negedge clk);
    check("b2b_idle", {31'b0, out_valid}, 32'd0);

    // Reset during DIVU iteration 10.
    op = OP_DIVU; a = 32'd1000; b = 32'd3; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (10) @(negedge clk);
    check("mid_busy_in_ready", {31'b0, in_ready}, 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check("abort_out_valid", {31'b0, out_valid}, 32'd0);
    check("abort_result", result, 32'd0);
    check("abort_zero", {31'b0, zero}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op("post_rst_add", OP_ADD, 32'd20, 32'd22, 32'd42, 1'b0, 1);
    run_op("post_rst_div", OP_DIVU, 32'd1000, 32'd3, 32'd333, 1'b0, 33);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
